// File: rtl/expr_result_unpacker.sv
// expr_result_unpacker
// Takes one packed 90-bit expression-result word {y0..y17} over valid/ready.
// Emits its 18 fields one per beat, y0 first, each extended to 6 bits.
// Field widths cycle 4,5,6. Fields 3-5, 9-11 and 15-17 are signed.
// A running XOR of the extended fields is reported on the last beat.
//
// state | meaning
// IDLE  | no word held, ready for a new word
// SEND  | presenting field idx_q of the held word
module expr_result_unpacker #(
  parameter bit SIGN_EXT = 1'b1,
  parameter int NFIELDS  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [89:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_field,
  output logic [4:0]  out_index,
  output logic        out_signed,
  output logic        out_last,
  output logic [5:0]  out_xor
);

  localparam logic [4:0] LAST = 5'(NFIELDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [89:0] buf_q, buf_d;
  logic [4:0]  idx_q, idx_d;
  logic [5:0]  acc_q, acc_d;

  logic [2:0]  fld_w;
  logic        fld_sg;
  logic [5:0]  top6;
  logic [5:0]  fld_ext;
  logic        is_last;

  function automatic logic [2:0] field_width(input logic [4:0] i);
    case (i)
      5'd0, 5'd3, 5'd6, 5'd9, 5'd12, 5'd15: field_width = 3'd4;
      5'd1, 5'd4, 5'd7, 5'd10, 5'd13, 5'd16: field_width = 3'd5;
      default:                               field_width = 3'd6;
    endcase
  endfunction

  function automatic logic field_signed(input logic [4:0] i);
    field_signed = (i >= 5'd3 && i <= 5'd5) || (i >= 5'd9 && i <= 5'd11) ||
                   (i >= 5'd15 && i <= 5'd17);
  endfunction

  // Field decode: the current field always sits at the top of the buffer.
  always_comb begin
    fld_w   = field_width(idx_q);
    fld_sg  = field_signed(idx_q);
    top6    = buf_q[89:84];
    is_last = (idx_q == LAST);
    case (fld_w)
      3'd4: begin
        if (SIGN_EXT && fld_sg) fld_ext = {{2{top6[5]}}, top6[5:2]};
        else                    fld_ext = {2'b00, top6[5:2]};
      end
      3'd5: begin
        if (SIGN_EXT && fld_sg) fld_ext = {top6[5], top6[5:1]};
        else                    fld_ext = {1'b0, top6[5:1]};
      end
      default: fld_ext = top6;
    endcase
  end

  // Next-state, datapath update and beat outputs.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_field  = 6'd0;
    out_index  = 5'd0;
    out_signed = 1'b0;
    out_last   = 1'b0;
    out_xor    = 6'd0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = in_word;
          idx_d   = 5'd0;
          acc_d   = 6'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid  = 1'b1;
        out_field  = fld_ext;
        out_index  = idx_q;
        out_signed = fld_sg;
        out_last   = is_last;
        // The next word may only enter when the last beat is leaving.
        in_ready   = is_last && out_ready;
        if (is_last) out_xor = acc_q ^ fld_ext;
        if (out_ready) begin
          if (!is_last) begin
            buf_d = buf_q << fld_w;
            acc_d = acc_q ^ fld_ext;
            idx_d = idx_q + 5'd1;
          end else begin
            acc_d = 6'd0;
            idx_d = 5'd0;
            if (in_valid) buf_d = in_word;
            else          state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= 5'd0;
      acc_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Bench for expr_result_unpacker: two instances (SIGN_EXT=1 and 0) share one
// handshake and are checked against a field-map model of the packed word.
module tb_expr_result_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [89:0] in_word = '0;

  logic        in_ready, out_valid, out_signed, out_last;
  logic [5:0]  out_field, out_xor;
  logic [4:0]  out_index;
  logic        in_ready0, out_valid0, out_signed0, out_last0;
  logic [5:0]  out_field0, out_xor0;
  logic [4:0]  out_index0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int hs_cnt = 0;

  logic [89:0] seq_words [4];
  logic [5:0]  obs1 [18];
  logic [5:0]  obs0 [18];
  logic        obss [18];
  logic [5:0]  obs_xor1, obs_xor0;

  expr_result_unpacker #(.SIGN_EXT(1'b1), .NFIELDS(18)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_field(out_field), .out_index(out_index), .out_signed(out_signed),
    .out_last(out_last), .out_xor(out_xor));

  expr_result_unpacker #(.SIGN_EXT(1'b0), .NFIELDS(18)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_word(in_word), .out_valid(out_valid0), .out_ready(out_ready),
    .out_field(out_field0), .out_index(out_index0), .out_signed(out_signed0),
    .out_last(out_last0), .out_xor(out_xor0));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: field i starts 15*(i/3) + {0,4,9}[i%3] bits below the MSB.
  function automatic logic [5:0] mdl(input logic [89:0] w, input int i, input bit se);
    int wd, off;
    logic [89:0] t;
    logic [5:0] raw;
    wd  = 4 + (i % 3);
    off = (i / 3) * 15 + ((i % 3) == 0 ? 0 : ((i % 3) == 1 ? 4 : 9));
    t   = w << off;
    raw = t[89:84] >> (6 - wd);
    if (se && ((i / 3) % 2 == 1) && raw[wd-1]) raw = raw | (6'h3F << wd);
    return raw;
  endfunction

  function automatic logic [5:0] mxor(input logic [89:0] w, input bit se);
    logic [5:0] x = 6'd0;
    for (int i = 0; i < 18; i++) x ^= mdl(w, i, se);
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_beat(input logic [89:0] w, input int i);
    #1;
    chk("out_valid", int'(out_valid), 1);
    chk("out_index", int'(out_index), i);
    chk("field_se1", int'(out_field), int'(mdl(w, i, 1'b1)));
    chk("field_se0", int'(out_field0), int'(mdl(w, i, 1'b0)));
    chk("out_signed", int'(out_signed), int'((i / 3) % 2 == 1));
    chk("out_last", int'(out_last), int'(i == 17));
    chk("in_ready", int'(in_ready), int'(i == 17 && out_ready));
    if (i == 17) begin
      chk("xor_se1", int'(out_xor), int'(mxor(w, 1'b1)));
      chk("xor_se0", int'(out_xor0), int'(mxor(w, 1'b0)));
      obs_xor1 = out_xor;
      obs_xor0 = out_xor0;
    end
    obs1[i] = out_field;
    obs0[i] = out_field0;
    obss[i] = out_signed;
  endtask

  // Streams seq_words[0..nwords-1]; follow-on words are offered during the
  // previous word's last beat. Optional stall of stall_n cycles at stall_idx.
  task automatic run_seq(input int nwords, input int stall_idx, input int stall_n);
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = seq_words[0];
    @(negedge clk);
    in_valid = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      for (int i = 0; i < 18; i++) begin
        if (i == stall_idx && stall_n > 0) begin
          out_ready = 1'b0;
          for (int s = 0; s < stall_n; s++) begin
            check_beat(seq_words[w], i);
            @(negedge clk);
          end
          out_ready = 1'b1;
        end
        if (i == 17 && w + 1 < nwords) begin
          in_valid = 1'b1;
          in_word  = seq_words[w + 1];
        end
        check_beat(seq_words[w], i);
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    #1;
    chk("idle_valid", int'(out_valid), 0);
    chk("idle_ready", int'(in_ready), 1);
  endtask

  typedef struct {
    logic [89:0] word;
    int          idx;
    logic [5:0]  f1;
    logic [5:0]  f0;
    logic        sg;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int c0, h0;
    logic [89:0] ones;
    ones = '1;
    tbl[0]  = '{90'h0, 0,  6'h00, 6'h00, 1'b0};
    tbl[1]  = '{90'h0, 17, 6'h00, 6'h00, 1'b1};
    tbl[2]  = '{ones,  0,  6'h0F, 6'h0F, 1'b0};
    tbl[3]  = '{ones,  1,  6'h1F, 6'h1F, 1'b0};
    tbl[4]  = '{ones,  2,  6'h3F, 6'h3F, 1'b0};
    tbl[5]  = '{ones,  3,  6'h3F, 6'h0F, 1'b1};
    tbl[6]  = '{ones,  4,  6'h3F, 6'h1F, 1'b1};
    tbl[7]  = '{ones,  5,  6'h3F, 6'h3F, 1'b1};
    tbl[8]  = '{ones,  6,  6'h0F, 6'h0F, 1'b0};
    tbl[9]  = '{ones,  9,  6'h3F, 6'h0F, 1'b1};
    tbl[10] = '{ones,  15, 6'h3F, 6'h0F, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_field", int'(out_field), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_signed", int'(out_signed), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_xor", int'(out_xor), 0);
    rst = 1'b0;

    // Directed field-map vectors
    for (int k = 0; k < 11; k++) begin
      seq_words[0] = tbl[k].word;
      run_seq(1, 99, 0);
      chk("tbl_field_se1", int'(obs1[tbl[k].idx]), int'(tbl[k].f1));
      chk("tbl_field_se0", int'(obs0[tbl[k].idx]), int'(tbl[k].f0));
      chk("tbl_signed", int'(obss[tbl[k].idx]), int'(tbl[k].sg));
    end
    seq_words[0] = ones;
    run_seq(1, 99, 0);
    chk("ones_xor_se1", int'(obs_xor1), 'h10);
    chk("ones_xor_se0", int'(obs_xor0), 'h00);
    seq_words[0] = '0;
    run_seq(1, 99, 0);
    chk("zero_xor", int'(obs_xor1), 0);

    // Backpressure: 3 stall cycles at idx5
    seq_words[0] = {$urandom, $urandom, 26'($urandom)};
    run_seq(1, 5, 3);

    // Back-to-back: 36 beats in 36 cycles
    seq_words[0] = {$urandom, $urandom, 26'($urandom)};
    seq_words[1] = {$urandom, $urandom, 26'($urandom)};
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = seq_words[0];
    @(negedge clk);
    in_valid = 1'b0;
    c0 = cyc;
    h0 = hs_cnt;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 18; i++) begin
        if (i == 17 && w == 0) begin
          in_valid = 1'b1;
          in_word  = seq_words[1];
        end
        check_beat(seq_words[w], i);
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    chk("b2b_cycles", cyc - c0, 36);
    chk("b2b_beats", hs_cnt - h0, 36);

    // Reset at idx9, then a fresh word with clean XOR
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = {$urandom, $urandom, 26'($urandom)};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("pre_rst_index", int'(out_index), 9);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_ready", int'(in_ready), 1);
    chk("rst_mid_last", int'(out_last), 0);
    rst = 1'b0;
    seq_words[0] = {$urandom, $urandom, 26'($urandom)};
    run_seq(1, 99, 0);

    // Randomized streams with random stalls
    for (int r = 0; r < 20; r++) begin
      int nw;
      nw = int'($urandom_range(1, 3));
      for (int k = 0; k < nw; k++) seq_words[k] = {$urandom, $urandom, 26'($urandom)};
      run_seq(nw, int'($urandom_range(0, 17)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
